// File: rtl/instr_issue_ctrl.sv
// rtl/instr_issue_ctrl.sv - round-robin write / circular-queue read sequencer for the instruction register
// Optional statistics counters: define INSTR_ISSUE_CTRL_STATS_EN.
module instr_issue_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = 32,
    parameter int AW      = $clog2(DEPTH),
    parameter int OPC_W   = 4,
    parameter int OP_W    = 32,
    parameter int IW_W    = OPC_W + 2*OP_W + 64,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     flush,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*OPC_W-1:0] req_opcode,
    input  logic [NUM_REQ*OP_W-1:0]  req_op_a,
    input  logic [NUM_REQ*OP_W-1:0]  req_op_b,
    output logic                     load_en,
    output logic [AW-1:0]            write_pointer,
    output logic [OPC_W-1:0]         opcode,
    output logic [OP_W-1:0]          operand_a,
    output logic [OP_W-1:0]          operand_b,
    output logic [AW-1:0]            read_pointer,
    input  logic [IW_W-1:0]          instruction_word,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IW_W-1:0]          out_instr,
    output logic [SRC_W-1:0]         out_src,
    output logic [AW:0]              count,
    output logic                     full,
    output logic                     empty
`ifdef INSTR_ISSUE_CTRL_STATS_EN
    ,
    output logic [15:0]              stat_issued,
    output logic [15:0]              stat_stall
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FLUSH} state_t;

    state_t             state_q, state_d;
    logic [SRC_W-1:0]   rr_q, rr_d;
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]        count_q;
    logic               load_en_q;
    logic [OPC_W-1:0]   opcode_q;
    logic [OP_W-1:0]    op_a_q, op_b_q;
    logic [SRC_W-1:0]   src_q;
    logic [SRC_W-1:0]   tag_mem [DEPTH];

    logic               grant_ok, found, hs, rd_hs, flush_go;
    logic [SRC_W-1:0]   gnt_idx, cand;
    int                 arb_idx;

    // A write still in flight occupies a slot, so it counts toward full.
    assign full      = (count_q + (AW+1)'(load_en_q)) == (AW+1)'(DEPTH);
    assign empty     = (count_q == '0);
    assign grant_ok  = (state_q == S_ACTIVE) && enable && !flush && !full;
    assign hs        = grant_ok && found;
    assign out_valid = (state_q != S_FLUSH) && (count_q != '0);
    assign rd_hs     = out_valid && out_ready;
    assign flush_go  = (state_q == S_ACTIVE) && flush;

    assign load_en       = load_en_q;
    assign write_pointer = wr_ptr_q;
    assign opcode        = opcode_q;
    assign operand_a     = op_a_q;
    assign operand_b     = op_b_q;
    assign read_pointer  = rd_ptr_q;
    assign out_instr     = instruction_word;
    assign out_src       = tag_mem[rd_ptr_q];
    assign count         = count_q;

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        arb_idx = 0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_idx = (int'(rr_q) + i) % NUM_REQ;
            cand    = SRC_W'(arb_idx);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (hs) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign rr_d = (gnt_idx == SRC_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (enable) state_d = S_ACTIVE;
            S_ACTIVE: begin
                if (flush) begin
                    state_d = S_FLUSH;
                end else if (!enable && count_q == '0 && !load_en_q) begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH:  state_d = enable ? S_ACTIVE : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            rr_q      <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            load_en_q <= 1'b0;
            opcode_q  <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            src_q     <= '0;
        end else begin
            state_q   <= state_d;
            load_en_q <= hs;
            if (hs) begin
                opcode_q <= req_opcode[gnt_idx*OPC_W +: OPC_W];
                op_a_q   <= req_op_a[gnt_idx*OP_W +: OP_W];
                op_b_q   <= req_op_b[gnt_idx*OP_W +: OP_W];
                src_q    <= gnt_idx;
                rr_q     <= rr_d;
            end
            // A write landing during the flush edge still reaches the RAM but is dropped here.
            if (flush_go) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (load_en_q) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (rd_hs)     rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q <= count_q + (AW+1)'(load_en_q) - (AW+1)'(rd_hs);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_en_q) begin
            tag_mem[wr_ptr_q] <= src_q;
        end
    end

`ifdef INSTR_ISSUE_CTRL_STATS_EN
    logic [15:0] issued_q, stall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else if (flush_go) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            if (rd_hs && issued_q != 16'hFFFF)              issued_q <= issued_q + 16'd1;
            if ((|req_valid) && full && stall_q != 16'hFFFF) stall_q  <= stall_q + 16'd1;
        end
    end

    assign stat_issued = issued_q;
    assign stat_stall  = stall_q;
`endif

endmodule
